seq_scan_ctrl: RTL and testbench
================================

Name: seq_scan_ctrl

Overview:
Word-level controller that sequences an overlapping Moore "1101" detector over buffered parallel data. It accepts a WORD_W-bit word over a valid/ready handshake and serialises it MSB-first into the detector sub-module. It counts detections across the word and returns the match count over a second valid/ready handshake. An optional continue flag carries detector state across word boundaries, so a pattern split between two words is still detected.

Parameters:
WORD_W, 8, bits per input word; legal range 4..64.
CNT_W, $clog2(WORD_W+1), width of the match count (localparam, not overridable).

Ports:
clk  input  1  single clock; all state updates on posedge
arstn  input  1  reset; synchronous, active-low (sampled only on posedge clk)
in_valid  input  1  in_word/in_cont valid
in_ready  output  1  controller can accept a word (high only in IDLE)
in_word  input  WORD_W  data word; bit WORD_W-1 is shifted first
in_cont  input  1  1 = keep detector state from previous word; 0 = clear detector to S0 at accept
out_valid  output  1  out_count valid
out_ready  input  1  consumer accepts out_count
out_count  output  CNT_W  number of detections in the word
match_pulse  output  1  high for one cycle per counted detection
busy  output  1  high in SHIFT, DRAIN, DONE

Behaviour:
- Reset (arstn low at posedge): controller goes to IDLE, shift reg = 0, bit_cnt = 0, count = 0, detector = S0. Outputs: in_ready=1 after reset, out_valid=0, out_count=0, match_pulse=0, busy=0. Reset mid-operation abandons the word; no result is produced.
- Controller FSM: IDLE, SHIFT, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid at posedge: load shreg=in_word, bit_cnt=0, count=0; if in_cont=0, the detector clears to S0 on the same edge. Next state is SHIFT.
- SHIFT: det_in = shreg[WORD_W-1]; detector advances one bit each cycle; shreg shifts left; bit_cnt++. After WORD_W cycles (bit_cnt==WORD_W-1), next state is DRAIN.
- Counting: det_out is registered and reflects the bit applied in the previous cycle.
  - count++ and match_pulse=1 when det_out=1 in SHIFT with bit_cnt>=1, or in DRAIN.
  - det_out in the first SHIFT cycle is ignored, because it belongs to the previous word and was already counted in that word's DRAIN.
- DRAIN: one cycle; counts the final bit's result; next state is DONE.
- DONE: out_valid=1 and out_count=count, both held stable until out_ready. On out_valid&&out_ready the FSM returns to IDLE; the detector state is retained for a possible in_cont=1.
- Latency: for a word accepted at edge 0, SHIFT occupies cycles 1..WORD_W, DRAIN is cycle WORD_W+1, and out_valid is first high in cycle WORD_W+2. Throughput is one word per WORD_W+3 cycles minimum.
- in_valid is ignored outside IDLE. in_word does not need to be held after accept.
- Detector (Moore, overlapping); out=1 only in S4. States and transitions:
  - S0 (no prefix): 1->S1, 0->S0
  - S1 ("1"): 1->S2, 0->S0
  - S2 ("11"): 1->S2, 0->S3
  - S3 ("110"): 1->S4, 0->S0
  - S4 ("1101"): 1->S2, 0->S0
  - The detector advances only when det_en=1 (SHIFT); otherwise it holds.
- Width: the count cannot overflow because detections ≤ WORD_W; no saturation logic is needed.
- Next-state and output logic is fully combinational over all inputs and defaults every output.

Decomposition:
- Package seq_scan_pkg:
  - ctrl_state_t enum (IDLE, SHIFT, DRAIN, DONE)
  - det_state_t enum (S0..S4, 3-bit)
  - PATTERN constant 4'b1101
- Sub-module seq_det_1101: ports clk, arstn, en, clr, din, dout, state. It contains the detector FSM only. The controller owns the shift register, bit counter, match counter and handshakes.

Test Plan:
- Basic (WORD_W=8): in_word=8'b1101_1010, in_cont=0 -> detector trace S1,S2,S3,S4,S2,S3,S4,S0; match_pulse twice; out_valid in cycle 10 with out_count=2.
- Overlap: 8'b1101_1101 -> out_count=2; 8'h00 -> out_count=0; 8'b1111_1111 -> out_count=0.
- Cross-word: word 8'b0000_0110 (count 0, detector ends S3), then 8'b1000_0000 with in_cont=1 -> out_count=1. Repeat the pair with in_cont=0 -> out_count=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid -> out_valid=1, out_count stable, in_ready=0, no word accepted. out_ready=1 -> IDLE next cycle.
- Reset mid-SHIFT: arstn=0 at SHIFT cycle 3 -> next cycle IDLE, in_ready=1, out_valid=0, out_count=0, detector S0. The next word (8'b1101_0000) yields out_count=1.
- Back-to-back: in_valid and out_ready held high for 4 words -> one accept every 11 cycles, and counts match a reference model.

Source files
------------

// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the word-level "1101" scan controller.
package seq_scan_pkg;

    localparam int unsigned CTRL_W = 2;
    localparam int unsigned DET_W  = 3;

    typedef enum logic [CTRL_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

    typedef enum logic [DET_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } det_state_t;

    localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/seq_det_1101.sv
// Overlapping Moore detector for PATTERN; dout is high only while in S4.
module seq_det_1101
    import seq_scan_pkg::*;
(
    input  logic       clk,
    input  logic       arstn,
    input  logic       en,
    input  logic       clr,
    input  logic       din,
    output logic       dout,
    output det_state_t state
);

    det_state_t r_state;
    det_state_t w_state_nxt;

    always_ff @(posedge clk) begin
        if (!arstn) begin
            r_state <= S0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Each state is the longest pattern prefix matching the recent bits; clr wins over en.
    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = S0;
        end else if (en) begin
            case (r_state)
                S0:      w_state_nxt = (din == PATTERN[3]) ? S1 : S0;
                S1:      w_state_nxt = (din == PATTERN[2]) ? S2 : S0;
                S2:      w_state_nxt = (din == PATTERN[1]) ? S3 : S2;
                S3:      w_state_nxt = (din == PATTERN[0]) ? S4 : S0;
                S4:      w_state_nxt = din ? S2 : S0;
                default: w_state_nxt = S0;
            endcase
        end
    end

    assign dout  = (r_state == S4);
    assign state = r_state;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts a word, serialises it MSB-first into the 1101 detector and returns the match count.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int unsigned WORD_W = 8
) (
    input  logic                               clk,
    input  logic                               arstn,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WORD_W-1:0]                  in_word,
    input  logic                               in_cont,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(WORD_W+1)-1:0]        out_count,
    output logic                               match_pulse,
    output logic                               busy
);

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

    ctrl_state_t         r_state;
    ctrl_state_t         w_state_nxt;
    logic [WORD_W-1:0]   r_shreg;
    logic [WORD_W-1:0]   w_shreg_nxt;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    w_bit_cnt_nxt;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic                w_det_en;
    logic                w_det_clr;
    logic                w_det_out;
    logic                w_count_hit;
    det_state_t          w_det_state;

    seq_det_1101 u_det (
        .clk   (clk),
        .arstn (arstn),
        .en    (w_det_en),
        .clr   (w_det_clr),
        .din   (r_shreg[WORD_W-1]),
        .dout  (w_det_out),
        .state (w_det_state)
    );

    always_ff @(posedge clk) begin
        if (!arstn) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_count   <= w_count_nxt;
        end
    end

    // The first SHIFT cycle sees the previous word's last result, already counted in its DRAIN.
    assign w_count_hit = w_det_out &&
                         (((r_state == SHIFT) && (r_bit_cnt != '0)) || (r_state == DRAIN));

    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bit_cnt_nxt = r_bit_cnt;
        w_count_nxt   = r_count;
        w_det_en      = 1'b0;
        w_det_clr     = 1'b0;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        busy          = 1'b0;
        match_pulse   = 1'b0;

        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_shreg_nxt   = in_word;
                    w_bit_cnt_nxt = '0;
                    w_count_nxt   = '0;
                    w_det_clr     = !in_cont;
                    w_state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                busy          = 1'b1;
                w_det_en      = 1'b1;
                w_shreg_nxt   = {r_shreg[WORD_W-2:0], 1'b0};
                w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                if (w_count_hit) begin
                    match_pulse = 1'b1;
                    w_count_nxt = r_count + CNT_W'(1);
                end
                if (r_bit_cnt == CNT_W'(WORD_W - 1)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (w_count_hit) begin
                    match_pulse = 1'b1;
                    w_count_nxt = r_count + CNT_W'(1);
                end
                w_state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign out_count = r_count;

    a_dout_is_s4: assert property (@(posedge clk) disable iff (!arstn)
        w_det_out == (w_det_state == S4));

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: cycle-level reference model plus directed literal checks.
module tb_seq_scan_ctrl;

    localparam int W     = 8;
    localparam int CNT_W = $clog2(W + 1);

    logic             clk = 1'b0;
    logic             arstn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     in_word = '0;
    logic             in_cont = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] out_count;
    logic             match_pulse;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    seq_scan_ctrl #(.WORD_W(W)) dut (
        .clk         (clk),
        .arstn       (arstn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_word     (in_word),
        .in_cont     (in_cont),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_count   (out_count),
        .match_pulse (match_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: detection at a bit means the last four bits since the last clear read 1101.
    logic [3:0]   m_hist  = '0;
    int           m_hlen  = 0;
    int           m_phase = 0;
    int           m_count = 0;
    logic [W+1:0] m_pulse = '0;
    logic         m_valid = 1'b0;
    logic         m_zero  = 1'b0;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("in_ready", int'(in_ready), int'(m_phase == 0));
            chk("busy", int'(busy), int'(m_phase != 0));
            chk("out_valid", int'(out_valid), int'(m_phase == W + 2));
            chk("match_pulse", int'(match_pulse),
                (m_phase >= 2 && m_phase <= W + 1) ? int'(m_pulse[m_phase]) : 0);
            if (m_phase == W + 2) chk("out_count", int'(out_count), m_count);
            else if (m_zero)      chk("out_count_rst", int'(out_count), 0);
        end
        if (!arstn) begin
            m_valid = 1'b1;
            m_zero  = 1'b1;
            m_phase = 0;
            m_hlen  = 0;
            m_hist  = '0;
            m_count = 0;
        end else if (m_valid) begin
            if (m_phase == 0) begin
                if (in_valid) begin
                    if (!in_cont) m_hlen = 0;
                    m_pulse = '0;
                    m_count = 0;
                    m_zero  = 1'b0;
                    for (int k = 0; k < W; k++) begin
                        m_hist = {m_hist[2:0], in_word[W-1-k]};
                        if (m_hlen < 4) m_hlen++;
                        if (m_hlen == 4 && m_hist == 4'b1101) begin
                            m_pulse[k+2] = 1'b1;
                            m_count++;
                        end
                    end
                    m_phase = 1;
                end
            end else if (m_phase < W + 2) begin
                m_phase++;
            end else if (out_ready) begin
                m_phase = 0;
            end
        end
    end

    // Offer one word, wait for its result with out_ready high, check count and latency.
    task automatic run_word(input logic [W-1:0] w, input logic c, input int exp, input string nm);
        int n;
        bit ok;
        @(posedge clk); #1;
        in_word = w; in_cont = c; in_valid = 1'b1; out_ready = 1'b1;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk({nm, "_accept_timeout"}, 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_word = W'($urandom);
        n = 0; ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n++;
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) chk({nm, "_result_timeout"}, 0, 1);
        chk({nm, "_count"}, int'(out_count), exp);
        chk({nm, "_model"}, m_count, exp);
        chk({nm, "_latency"}, n, W + 2);
    endtask

    initial begin
        int acc[$];
        bit ok;
        repeat (3) @(posedge clk);
        #1 arstn = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_count", int'(out_count), 0);

        run_word(8'b1101_1010, 1'b0, 2, "basic");
        run_word(8'b1101_1101, 1'b0, 2, "overlap");
        run_word(8'h00,        1'b0, 0, "zeros");
        run_word(8'hFF,        1'b0, 0, "ones");
        run_word(8'b0000_0110, 1'b0, 0, "cross_a");
        run_word(8'b1000_0000, 1'b1, 1, "cross_b_cont");
        run_word(8'b0000_0110, 1'b0, 0, "cross_c");
        run_word(8'b1000_0000, 1'b0, 0, "cross_d_clr");

        // Backpressure: result held while in_valid toggles.
        @(posedge clk); #1;
        in_word = 8'b1101_0000; in_cont = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("bp_accept_timeout", 0, 1);
        @(posedge clk); #1 in_valid = 1'b0;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1; break; end
        end
        if (!ok) chk("bp_result_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = ~in_valid; in_word = W'($urandom);
            @(negedge clk);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_count", int'(out_count), 1);
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_release", int'(in_ready), 1);

        // Reset during the third SHIFT cycle abandons the word.
        @(posedge clk); #1;
        in_word = 8'hD6; in_cont = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 arstn = 1'b0;
        @(posedge clk); #1 arstn = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", int'(in_ready), 1);
        chk("rst_mid_out_valid", int'(out_valid), 0);
        chk("rst_mid_out_count", int'(out_count), 0);
        run_word(8'b1101_0000, 1'b1, 1, "after_rst");

        // Back-to-back: accept spacing must be WORD_W+3 cycles.
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b1; in_cont = 1'($urandom); in_word = W'($urandom);
        for (int i = 0; i < 80 && acc.size() < 4; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc.push_back(cyc);
                @(posedge clk); #1;
                in_cont = 1'($urandom); in_word = W'($urandom);
            end
        end
        chk("b2b_accepts", acc.size(), 4);
        for (int i = 1; i < acc.size(); i++) chk("b2b_spacing", acc[i] - acc[i-1], W + 3);
        @(posedge clk); #1 in_valid = 1'b0;

        // Randomised traffic with occasional resets; the model checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_word   = W'($urandom);
            in_cont   = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            arstn     = ($urandom_range(0, 299) != 0);
        end
        @(posedge clk); #1 arstn = 1'b1; in_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
